// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial signed/unsigned add/subtract with overflow, carry/borrow, zero and negative flags
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             ci,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             of,
    output logic             co,
    output logic             z,
    output logic             n
);
    localparam int N = WIDTH / DIGIT;
    localparam int KW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] xa, bs, r_nxt;
    logic [KW-1:0]    k;
    logic             c, opl;
    logic [DIGIT:0]   sum;

    if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // Subtraction runs as x + ~y + ~ci, so the datapath below is a plain adder slice.
    always_comb begin
        sum = {1'b0, xa[k*DIGIT +: DIGIT]} + {1'b0, bs[k*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, c};
        r_nxt = r;
        r_nxt[k*DIGIT +: DIGIT] = sum[DIGIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            c     <= 1'b0;
            opl   <= 1'b0;
            xa    <= '0;
            bs    <= '0;
            r     <= '0;
            of    <= 1'b0;
            co    <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xa    <= x;
                    bs    <= op ? ~y : y;
                    c     <= op ? ~ci : ci;
                    opl   <= op;
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    r <= r_nxt;
                    c <= sum[DIGIT];
                    if (k == KW'(N - 1)) begin
                        co    <= opl ? ~sum[DIGIT] : sum[DIGIT];
                        of    <= (xa[WIDTH-1] == bs[WIDTH-1]) && (r_nxt[WIDTH-1] != xa[WIDTH-1]);
                        z     <= r_nxt == '0;
                        n     <= r_nxt[WIDTH-1];
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle signed/unsigned add-subtract unit with overflow, carry/borrow, zero and negative flags. It processes DIGIT bits per clock through a registered ripple slice. Operands are accepted and results returned over valid/ready handshakes. It is the area-reduced, width-generic successor to the 8-bit combinational adder/subtractor and sits between the operand register file and the result writeback path.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise). N = WIDTH/DIGIT.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op/ci valid.
- in_ready  output  1  unit can accept operands (high only in IDLE).
- op  input  1  0: r = x + y + ci; 1: r = x − y − ci.
- ci  input  1  carry-in (add) / borrow-in (sub).
- x  input  WIDTH  operand A, two's complement.
- y  input  WIDTH  operand B, two's complement.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- r  output  WIDTH  result, modulo 2^WIDTH.
- of  output  1  signed overflow.
- co  output  1  add: unsigned carry-out; sub: unsigned borrow-out.
- z  output  1  r == 0.
- n  output  1  r[WIDTH−1].

## Operation
- States: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, register x into xa and b into bs, where b = op ? ~y : y. Set carry register c = op ? ~ci : ci, latch op, clear digit counter k = 0, and go to RUN.
- RUN: each cycle, add digit k of xa, bs and c; write sum digit k of r and update c with the digit carry-out. When k == N−1, capture flags and go to DONE. Otherwise increment k.
- Flag capture (final cycle):
  - co = op ? ~c_final : c_final.
  - of = (xa[MSB] == bs[MSB]) && (r[MSB] != xa[MSB]), evaluated on the final r.
  - z = (final r == 0); n = final r[MSB].
- DONE: r and flags are held stable. On out_valid && out_ready, go to IDLE. in_valid is ignored outside IDLE.
- Arithmetic: every width is exactly WIDTH; the only carry out of the MSB is reflected in co. Subtraction is x + ~y + ~ci.
- Reset (any state, including mid-RUN): state = IDLE, k = 0, c = 0, r = 0, of = co = z = n = 0, out_valid = 0. The in-flight operation is discarded and never produces out_valid. in_ready = 1 in the first cycle after reset deasserts.
- Inputs x, y, op and ci may change freely after acceptance; the result depends only on the values sampled at the accept edge.

## Timing
- Accept edge E0. RUN occupies the N cycles after E0, and out_valid rises after edge E0+N. Latency is N cycles from accept to out_valid.
- Result drain edge Ed (out_valid && out_ready): in_ready is high in the cycle after Ed, so the next accept is at Ed+1 at the earliest.
- Minimum throughput: one operation per N+2 cycles when out_ready is held high.
- With out_ready low, DONE is held indefinitely and r and the flags do not change.
- rst has priority over every handshake in the same cycle.
- Outputs r, of, co, z and n are registers. in_ready and out_valid are decoded directly from state registers, with no combinational path from any input.

## Test plan
- WIDTH=8, DIGIT=1, add: x=100, y=27, ci=0 -> r=127, of=0, co=0, z=0, n=0. Also x=100, y=28 -> r=0x80, of=1, co=0, n=1. out_valid rises 8 cycles after accept.
- WIDTH=8, sub: x=5, y=7, ci=0 -> r=0xFE, co=1, of=0, n=1. Also x=10, y=3, ci=1 -> r=6, co=0, of=0.
- WIDTH=8, boundaries: sub x=0x80, y=1, ci=0 -> r=0x7F, of=1, co=0. Add x=0xFF, y=0x01, ci=0 -> r=0x00, co=1, z=1, of=0.
- WIDTH=16, DIGIT=4, add x=0x7FFF, y=0x0001 -> r=0x8000, of=1, out_valid 4 cycles after accept. Hold out_ready low 3 cycles: r is stable and in_ready stays 0. The next accept occurs one cycle after the drain edge.
- WIDTH=8, DIGIT=2: assert rst on the 2nd RUN cycle -> out_valid never rises, all outputs 0, in_ready=1 the cycle after rst deasserts. A new op x=1, y=1 -> r=2.
- Randomised 10k ops over WIDTH ∈ {8, 12, 32} and DIGIT ∈ {1, 2, 4} with random in_valid/out_ready gaps; compare r, of, co, z and n against a behavioural model.
